// File: rtl/cnn16_io_buffer.sv
// cnn16_io_buffer: host<->INPR/OUTR FIFO pair with Mano-style FGI/FGO flags, interrupt and sticky errors
module cnn16_io_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        inpr_data,
  input  logic                     inpr_rd,
  output logic                     fgi,
  input  logic [DATA_W-1:0]        outr_data,
  input  logic                     outr_wr,
  output logic                     fgo,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  input  logic                     ien_set,
  input  logic                     ien_clr,
  output logic                     irq,
  input  logic                     err_clr,
  output logic                     err_unf,
  output logic                     err_ovf,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic [$clog2(DEPTH):0]   out_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [DATA_W-1:0] in_mem_q [DEPTH];
  logic [DATA_W-1:0] out_mem_q [DEPTH];
  logic [PTR_W-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d, out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic ien_q, ien_d, irq_q, irq_d, err_unf_q, err_unf_d, err_ovf_q, err_ovf_d;
  logic in_push, in_pop, out_push, out_pop;
  assign in_ready  = !rst && in_cnt_q != FULL;
  assign fgi       = in_cnt_q != '0;
  assign fgo       = out_cnt_q != FULL;
  assign out_valid = out_cnt_q != '0;
  assign inpr_data = fgi ? in_mem_q[in_rd_q] : '0;
  assign out_data  = out_valid ? out_mem_q[out_rd_q] : '0;
  assign in_push   = in_valid & in_ready;
  assign in_pop    = inpr_rd & fgi;
  assign out_push  = outr_wr & fgo;
  assign out_pop   = out_valid & out_ready;
  assign in_count  = in_cnt_q;
  assign out_count = out_cnt_q;
  assign irq       = irq_q;
  assign err_unf   = err_unf_q;
  assign err_ovf   = err_ovf_q;
  always_comb begin
    in_wr_d   = in_push ? in_wr_q + 1'b1 : in_wr_q;
    in_rd_d   = in_pop ? in_rd_q + 1'b1 : in_rd_q;
    out_wr_d  = out_push ? out_wr_q + 1'b1 : out_wr_q;
    out_rd_d  = out_pop ? out_rd_q + 1'b1 : out_rd_q;
    in_cnt_d  = in_cnt_q + CNT_W'(in_push) - CNT_W'(in_pop);
    out_cnt_d = out_cnt_q + CNT_W'(out_push) - CNT_W'(out_pop);
    ien_d     = ien_clr ? 1'b0 : (ien_set | ien_q);
    // irq tracks the flags as they will be after this edge
    irq_d     = ien_d & (in_cnt_d != '0 || out_cnt_d != FULL);
    err_unf_d = (inpr_rd & !fgi) | (err_unf_q & !err_clr);
    err_ovf_d = (outr_wr & !fgo) | (err_ovf_q & !err_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ien_q     <= 1'b0;
      irq_q     <= 1'b0;
      err_unf_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ien_q     <= ien_d;
      irq_q     <= irq_d;
      err_unf_q <= err_unf_d;
      err_ovf_q <= err_ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_q] <= in_data;
    if (out_push && !rst) out_mem_q[out_wr_q] <= outr_data;
  end
endmodule
